// File: rtl/counter_run_controller.sv
// Run sequencer for a SIZE-bit binary counter: clear, count to target, pulse done.
// Optional AUTO_RELOAD_EN: DONE loops back to CLEAR with the same latched target.
module counter_run_controller #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] target,
  input  logic            pause,
  input  logic            abort,
  input  logic [SIZE-1:0] count,
  output logic            cnt_enable,
  output logic            cnt_clear,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [SIZE-1:0] target_q;
  logic            at_target;

  assign at_target = (count == target_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      target_q <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= CLEAR;
          target_q <= target;
        end
        CLEAR: state <= RUN;
        // a paused cycle never advances, even when the target is already reached
        RUN: if (at_target && !pause) state <= DONE;
`ifdef AUTO_RELOAD_EN
        DONE: state <= CLEAR;
`else
        DONE: state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // abort gates the counter controls combinationally so they drop in its own cycle
  always_comb begin
    cnt_clear  = (state == CLEAR) && !abort;
    cnt_enable = (state == RUN) && !pause && !at_target && !abort;
    busy       = (state == CLEAR) || (state == RUN);
    done       = (state == DONE);
  end

endmodule
